// File: rtl/zvc_stream_compressor.sv
// zvc_stream_compressor: two-stage zero-value compaction of LIFM/MT lines.
// Optional feature macro ZVC_STATS_EN adds emitted-line and bubble counters.
module zvc_stream_compressor #(
    parameter int NUM_LANES     = 128,
    parameter int WORD_WIDTH    = 8,
    parameter int DIST_WIDTH    = 7,
    parameter int MAX_LIFM_RSIZ = 4,
    parameter int DROP_EMPTY    = 0,
    localparam int ML = DIST_WIDTH * MAX_LIFM_RSIZ,
    localparam int CW = $clog2(NUM_LANES) + 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_LANES*WORD_WIDTH-1:0] lifm_line,
    input  logic [NUM_LANES*ML-1:0]         mt_line,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*WORD_WIDTH-1:0] lifm_comp,
    output logic [NUM_LANES*ML-1:0]         mt_comp,
    output logic [CW-1:0]                   out_count
`ifdef ZVC_STATS_EN
    ,
    input  logic                            stat_clear,
    output logic [31:0]                     stat_lines,
    output logic [31:0]                     stat_bubbles
`endif
);
    localparam int LW = NUM_LANES * WORD_WIDTH;
    localparam int MW = NUM_LANES * ML;

    logic                         s1_valid_q, s2_valid_q;
    logic [LW-1:0]                s1_lifm_q, s2_lifm_q, s2_lifm_d;
    logic [MW-1:0]                s1_mt_q, s2_mt_q, s2_mt_d;
    logic [NUM_LANES-1:0]         s1_bub_q, s1_bub_d;
    logic [NUM_LANES-1:0][CW-1:0] s1_pre_q, s1_pre_d;
    logic [CW-1:0]                s2_cnt_q, s2_cnt_d;
    logic                         s1_adv, s2_adv, s2_load;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Mark zero-MT lanes as bubbles and count the bubbles strictly below each lane.
    always_comb begin
        logic [CW-1:0] acc;
        acc      = '0;
        s1_bub_d = '0;
        s1_pre_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            s1_bub_d[i] = (mt_line[i*ML +: ML] == '0);
            s1_pre_d[i] = acc;
            acc         = acc + {{(CW-1){1'b0}}, s1_bub_d[i]};
        end
    end

    // Each surviving lane slides down by the number of bubbles beneath it.
    always_comb begin
        s2_lifm_d = '0;
        s2_mt_d   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!s1_bub_q[i]) begin
                s2_lifm_d[(i - int'(s1_pre_q[i]))*WORD_WIDTH +: WORD_WIDTH] = s1_lifm_q[i*WORD_WIDTH +: WORD_WIDTH];
                s2_mt_d[(i - int'(s1_pre_q[i]))*ML +: ML] = s1_mt_q[i*ML +: ML];
            end
        end
        s2_cnt_d = CW'(NUM_LANES) - s1_pre_q[NUM_LANES-1] - {{(CW-1){1'b0}}, s1_bub_q[NUM_LANES-1]};
        s2_load  = s1_valid_q && !((DROP_EMPTY != 0) && (s2_cnt_d == '0));
    end

    // Stage 1: capture the accepted line with its bubble mask and prefix counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_lifm_q  <= '0;
            s1_mt_q    <= '0;
            s1_bub_q   <= '0;
            s1_pre_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_lifm_q <= lifm_line;
                s1_mt_q   <= mt_line;
                s1_bub_q  <= s1_bub_d;
                s1_pre_q  <= s1_pre_d;
            end
        end
    end

    // Stage 2: hold the compacted line; empty lines are skipped when dropping is enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_lifm_q  <= '0;
            s2_mt_q    <= '0;
            s2_cnt_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s2_load;
            if (s2_load) begin
                s2_lifm_q <= s2_lifm_d;
                s2_mt_q   <= s2_mt_d;
                s2_cnt_q  <= s2_cnt_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign lifm_comp = s2_lifm_q;
    assign mt_comp   = s2_mt_q;
    assign out_count = s2_cnt_q;

`ifdef ZVC_STATS_EN
    logic [31:0]   stat_lines_q, stat_lines_d, stat_bubbles_q, stat_bubbles_d;
    logic [CW-1:0] freed;
    logic [32:0]   bub_sum;
    logic          emit;

    // Saturating statistics update for each emitted line.
    always_comb begin
        emit           = out_valid && out_ready;
        freed          = CW'(NUM_LANES) - out_count;
        bub_sum        = {1'b0, stat_bubbles_q} + {{(33-CW){1'b0}}, freed};
        stat_lines_d   = (stat_lines_q == '1) ? stat_lines_q : stat_lines_q + 32'd1;
        stat_bubbles_d = bub_sum[32] ? '1 : bub_sum[31:0];
    end

    // Counters: synchronous clear wins over a same-cycle emit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_lines_q   <= '0;
            stat_bubbles_q <= '0;
        end else if (stat_clear) begin
            stat_lines_q   <= '0;
            stat_bubbles_q <= '0;
        end else if (emit) begin
            stat_lines_q   <= stat_lines_d;
            stat_bubbles_q <= stat_bubbles_d;
        end
    end

    assign stat_lines   = stat_lines_q;
    assign stat_bubbles = stat_bubbles_q;
`endif
endmodule

// File: tb/tb_zvc_stream_compressor.sv
// tb_zvc_stream_compressor: randomized scoreboard bench for the ZVC compressor.
`timescale 1ns/1ps
module tb_zvc_stream_compressor;
    localparam int NL = 8;
    localparam int WW = 8;
    localparam int DW = 7;
    localparam int MR = 4;
    localparam int ML = DW * MR;
    localparam int CW = $clog2(NL) + 1;
    localparam int LW = NL * WW;
    localparam int MW = NL * ML;

    logic          clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, e_valid = 1'b0;
    logic          in_ready, out_valid, e_in_ready, e_out_valid;
    logic [LW-1:0] lifm_line = '0, lifm_comp, e_lifm;
    logic [MW-1:0] mt_line = '0, mt_comp, e_mt;
    logic [CW-1:0] out_count, e_count;
`ifdef ZVC_STATS_EN
    logic          stat_clear = 1'b0;
    logic [31:0]   stat_lines, stat_bubbles, e_sl, e_sb;
`endif

    zvc_stream_compressor #(.NUM_LANES(NL), .WORD_WIDTH(WW), .DIST_WIDTH(DW), .MAX_LIFM_RSIZ(MR), .DROP_EMPTY(0)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .lifm_line(lifm_line), .mt_line(mt_line), .out_valid(out_valid), .out_ready(out_ready),
        .lifm_comp(lifm_comp), .mt_comp(mt_comp), .out_count(out_count)
`ifdef ZVC_STATS_EN
        , .stat_clear(stat_clear), .stat_lines(stat_lines), .stat_bubbles(stat_bubbles)
`endif
    );

    zvc_stream_compressor #(.NUM_LANES(NL), .WORD_WIDTH(WW), .DIST_WIDTH(DW), .MAX_LIFM_RSIZ(MR), .DROP_EMPTY(1)) dut_drop (
        .clk(clk), .reset_n(reset_n), .in_valid(e_valid), .in_ready(e_in_ready),
        .lifm_line(lifm_line), .mt_line(mt_line), .out_valid(e_out_valid), .out_ready(1'b1),
        .lifm_comp(e_lifm), .mt_comp(e_mt), .out_count(e_count)
`ifdef ZVC_STATS_EN
        , .stat_clear(1'b0), .stat_lines(e_sl), .stat_bubbles(e_sb)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0, n_acc = 0, n0 = 0;
    bit lat_mode = 1'b0, done = 1'b0, held = 1'b0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: walk lanes in order, appending every lane whose MT is nonzero.
    function automatic void compress(input logic [LW-1:0] l, input logic [MW-1:0] m,
                                     output logic [LW-1:0] ol, output logic [MW-1:0] om, output int cnt);
        ol = '0;
        om = '0;
        cnt = 0;
        for (int i = 0; i < NL; i++) begin
            if (m[i*ML +: ML] != '0) begin
                ol[cnt*WW +: WW] = l[i*WW +: WW];
                om[cnt*ML +: ML] = m[i*ML +: ML];
                cnt++;
            end
        end
    endfunction

    task automatic rand_line(output logic [LW-1:0] l, output logic [MW-1:0] m);
        int mode;
        logic [ML-1:0] lane;
        mode = $urandom_range(0, 9);
        for (int i = 0; i < NL; i++) begin
            l[i*WW +: WW] = WW'($urandom);
            lane = ML'($urandom);
            if (lane == '0) lane = 1;
            if (mode == 0 || (mode > 1 && $urandom_range(0, 2) == 0)) lane = '0;
            m[i*ML +: ML] = lane;
        end
    endtask

    task automatic mask_line(input logic [NL-1:0] mask, output logic [LW-1:0] l, output logic [MW-1:0] m);
        for (int i = 0; i < NL; i++) begin
            l[i*WW +: WW] = WW'($urandom);
            m[i*ML +: ML] = mask[i] ? ML'($urandom_range(1, 1000)) : '0;
        end
    endtask

    task automatic send(input logic [LW-1:0] l, input logic [MW-1:0] m);
        logic ok;
        in_valid = 1'b1;
        lifm_line = l;
        mt_line = m;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("send_timeout", 1, 0);
    endtask

    logic [LW-1:0] q_l[$];
    logic [MW-1:0] q_m[$];
    int            q_c[$];
    int            q_t[$];

    task automatic drain();
        for (int t = 0; t < 500 && q_c.size() != 0; t++) @(negedge clk);
        chk("drain", q_c.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    logic [LW-1:0] m_l, h_l;
    logic [MW-1:0] m_m, h_m;
    logic [CW-1:0] h_c;
    int            m_c;

    // Scoreboard: predicts each accepted line, checks emitted lines and stalled-output stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_lifm", lifm_comp, h_l);
                chk("hold_mt", mt_comp, h_m);
                chk("hold_count", out_count, h_c);
            end
            held = out_valid && !out_ready;
            h_l = lifm_comp;
            h_m = mt_comp;
            h_c = out_count;
            if (out_valid && out_ready) begin
                if (q_c.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("out_lifm", lifm_comp, q_l.pop_front());
                    chk("out_mt", mt_comp, q_m.pop_front());
                    chk("out_count", out_count, q_c.pop_front());
                    m_c = q_t.pop_front();
                    if (lat_mode) chk("latency", cyc - m_c, 2);
                end
            end
            if (in_valid && in_ready) begin
                compress(lifm_line, mt_line, m_l, m_m, m_c);
                q_l.push_back(m_l);
                q_m.push_back(m_m);
                q_c.push_back(m_c);
                q_t.push_back(cyc);
                n_acc++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [LW-1:0] l34, tl;
    logic [MW-1:0] m34, tm;
    int            stale;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_lifm", lifm_comp, 0);
        chk("rst_mt", mt_comp, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        chk("post_rst_in_ready", in_ready, 1);

        // Lanes 1,4,6 survive out of 0x10..0x17.
        for (int i = 0; i < NL; i++) begin
            l34[i*WW +: WW] = WW'(8'h10 + i);
            m34[i*ML +: ML] = (i == 1 || i == 4 || i == 6) ? ML'(i * 3 + 1) : '0;
        end
        out_ready = 1'b1;
        lat_mode = 1'b1;
        send(l34, m34);
        @(posedge clk);
        #1;
        chk("sparse_valid", out_valid, 1);
        chk("sparse_lifm", lifm_comp, 64'h0000_0000_0016_1411);
        chk("sparse_count", out_count, 3);
        drain();

        send(l34, '0);
        @(posedge clk);
        #1;
        chk("empty_valid", out_valid, 1);
        chk("empty_count", out_count, 0);
        chk("empty_lifm", lifm_comp, 0);
        chk("empty_mt", mt_comp, 0);
        drain();

        // Drop-enabled instance: empty line vanishes, following line still emitted.
        e_valid = 1'b1;
        lifm_line = l34;
        mt_line = '0;
        @(posedge clk);
        #1;
        mt_line = m34;
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        chk("drop_empty_valid", e_out_valid, 0);
        @(posedge clk);
        #1;
        chk("drop_next_valid", e_out_valid, 1);
        chk("drop_next_count", e_count, 3);
        chk("drop_next_lifm", e_lifm, 64'h0000_0000_0016_1411);
        @(posedge clk);
        #1;
        chk("drop_idle", e_out_valid, 0);

        for (int k = 0; k < 20; k++) begin
            rand_line(tl, tm);
            send(tl, tm);
        end
        drain();
        lat_mode = 1'b0;

        // Downstream stalls for 5 cycles while input keeps coming.
        out_ready = 1'b0;
        n0 = n_acc;
        fork
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_accepts", n_acc - n0, 2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        for (int k = 0; k < 8; k++) begin
            rand_line(tl, tm);
            send(tl, tm);
        end
        drain();

        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    rand_line(tl, tm);
                    send(tl, tm);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

`ifdef ZVC_STATS_EN
        stat_clear = 1'b1;
        @(posedge clk);
        #1;
        stat_clear = 1'b0;
        mask_line(8'b1010_0100, tl, tm);
        send(tl, tm);
        mask_line(8'hFF, tl, tm);
        send(tl, tm);
        mask_line(8'h00, tl, tm);
        send(tl, tm);
        drain();
        chk("stat_lines", stat_lines, 3);
        chk("stat_bubbles", stat_bubbles, 13);
        mask_line(8'h0F, tl, tm);
        send(tl, tm);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("stat_emit_seen", out_valid, 1);
        stat_clear = 1'b1;
        @(posedge clk);
        #1;
        stat_clear = 1'b0;
        chk("stat_clr_lines", stat_lines, 0);
        chk("stat_clr_bubbles", stat_bubbles, 0);
        drain();
`endif

        // Reset with two lines in flight.
        out_ready = 1'b0;
        rand_line(tl, tm);
        tm[ML-1:0] = 1;
        send(tl, tm);
        rand_line(tl, tm);
        send(tl, tm);
        chk("inflight_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_count", out_count, 0);
        chk("arst_lifm", lifm_comp, 0);
        chk("arst_mt", mt_comp, 0);
        chk("arst_in_ready", in_ready, 1);
        q_l.delete();
        q_m.delete();
        q_c.delete();
        q_t.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale_output", stale, 0);
        @(posedge clk);
        #1;
        rand_line(tl, tm);
        send(tl, tm);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/zvc_stream_compressor.md
ZVC_STREAM_COMPRESSOR -- requirements
Module: zvc_stream_compressor

Interface
REQ-001 SHALL have parameter NUM_LANES, default 128, lanes per line; power of two, 4..256.
REQ-002 SHALL have parameter WORD_WIDTH, default 8, LIFM word width.
REQ-003 SHALL have parameter DIST_WIDTH, default 7, mapping-table distance field width.
REQ-004 SHALL have parameter MAX_LIFM_RSIZ, default 4, distance fields per lane; MT lane width ML = DIST_WIDTH*MAX_LIFM_RSIZ.
REQ-005 SHALL have parameter DROP_EMPTY, default 0; 1 = lines with zero surviving lanes are not emitted.
REQ-006 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1, input line valid.
REQ-009 SHALL have port in_ready, output, 1, block accepts the line this cycle.
REQ-010 SHALL have port lifm_line, input, NUM_LANES*WORD_WIDTH, lowered IFM line; lane i at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-011 SHALL have port mt_line, input, NUM_LANES*ML, mapping table line; lane i at bits [i*ML +: ML].
REQ-012 SHALL have port out_valid, output, 1, compressed line valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts.
REQ-014 SHALL have port lifm_comp, output, NUM_LANES*WORD_WIDTH, compacted LIFM.
REQ-015 SHALL have port mt_comp, output, NUM_LANES*ML, compacted MT.
REQ-016 SHALL have port out_count, output, clog2(NUM_LANES)+1, number of surviving lanes.

Function
REQ-017 SHALL treat lane i as a bubble iff its MT lane equals zero, irrespective of LIFM value.
REQ-018 SHALL pack surviving lanes into lanes 0..out_count-1 in ascending original order, both LIFM and MT moved identically; lanes >= out_count SHALL be zero.
REQ-019 SHALL transfer input on in_valid&&in_ready, and output on out_valid&&out_ready.
REQ-020 SHALL be a two-stage pipeline: S1 registers line, bubble mask and exclusive prefix count of bubbles; S2 registers the compacted line and out_count.
REQ-021 SHALL present an accepted line on the outputs exactly 2 cycles after acceptance when out_ready is held high, sustaining one line per cycle.
REQ-022 SHALL advance S2 when S2 is empty or out_ready=1, and S1 when S1 is empty or S2 advances; in_ready = !S1_valid || S2_advance.
REQ-023 SHALL hold lifm_comp, mt_comp and out_count stable while out_valid=1 and out_ready=0.
REQ-024 SHALL never drop, duplicate or reorder lines under any in_valid/out_ready pattern.
REQ-025 SHALL, when DROP_EMPTY=1, discard a line with zero surviving lanes at the S1->S2 transfer, leaving S2 unloaded; with DROP_EMPTY=0 it SHALL emit it with out_count=0 and all-zero data.
REQ-026 SHALL emit a line with no bubbles unchanged with out_count=NUM_LANES.
REQ-027 SHALL allow simultaneous accept and emit in the same cycle without a bubble in throughput.

Reset
REQ-028 SHALL, on reset_n low, immediately clear both stage valids and all data registers: out_valid=0, lifm_comp=0, mt_comp=0, out_count=0.
REQ-029 SHALL drive in_ready=1 during reset and on the first cycle after release.
REQ-030 SHALL discard lines in flight when reset asserts mid-operation; no output after release until a new acceptance.

Configuration
REQ-031 SHALL, with macro ZVC_STATS_EN defined, add input stat_clear (1) and outputs stat_lines (32) and stat_bubbles (32).
REQ-032 SHALL, with ZVC_STATS_EN, increment stat_lines per emitted line, add NUM_LANES-out_count to stat_bubbles per emitted line, saturate at all-ones, reset to 0, and on synchronous stat_clear load 0, clear taking priority over increment.
REQ-033 SHALL, without ZVC_STATS_EN, omit these ports and counters, all other behaviour identical.

Verification (NUM_LANES=8, WORD_WIDTH=8, DIST_WIDTH=7, MAX_LIFM_RSIZ=4)
REQ-034 SHALL cover: LIFM lanes 0..7 = 0x10..0x17, MT nonzero on lanes 1,4,6 only -> 2 cycles later lifm_comp lanes 0..2 = 0x11,0x14,0x16, rest 0, out_count=3.
REQ-035 SHALL cover: all MT lanes zero, DROP_EMPTY=0 -> out_valid with out_count=0 and data 0; DROP_EMPTY=1 -> no out_valid, next line emitted normally.
REQ-036 SHALL cover: 20 back-to-back lines with out_ready=1 -> 20 outputs on consecutive cycles, first at cycle 2.
REQ-037 SHALL cover: out_ready=0 for 5 cycles with continuous in_valid -> in_ready low after 2 accepted lines, outputs held stable, order preserved on resume.
REQ-038 SHALL cover: reset_n pulsed low with 2 lines in flight -> out_valid=0 immediately, no stale output afterward.
REQ-039 SHALL cover, with ZVC_STATS_EN: 3 lines with 5, 0, 8 bubbles emitted -> stat_lines=3, stat_bubbles=13; stat_clear in the same cycle as an emit -> both counters 0.
